span_walker: RTL and testbench

SPAN_WALKER -- requirements
Module: span_walker

---
 rtl/span_walker_pkg.sv | 80 ++++++++
 rtl/span_walker_if.sv | 21 ++
 rtl/edge_acc.sv | 29 ++
 rtl/span_walker.sv | 133 +++++++++++++
 tb/tb_span_walker.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/span_walker_pkg.sv
// Shared pipeline package: setup-record and span-record layouts, field widths,
// walker FSM encodings and the saturation helpers used when packing spans.
package span_walker_pkg;

    localparam int unsigned CmdW   = 8;
    localparam int unsigned CoordW = 6;
    localparam int unsigned FracW  = 6;
    localparam int unsigned SlopeW = 13;  // s6.6
    localparam int unsigned Z1W    = 10;
    localparam int unsigned ZW     = 17;  // s10.6
    localparam int unsigned R1W    = 5;
    localparam int unsigned RW     = 12;  // s5.6
    localparam int unsigned G1W    = 6;
    localparam int unsigned GW     = 13;  // s6.6
    localparam int unsigned B1W    = 5;
    localparam int unsigned BW     = 12;  // s5.6

    // Accumulators carry one extra integer bit over their output field.
    localparam int unsigned XAccW = SlopeW + 1;
    localparam int unsigned ZAccW = ZW + 1;
    localparam int unsigned RAccW = RW + 1;
    localparam int unsigned GAccW = GW + 1;
    localparam int unsigned BAccW = BW + 1;

    // Field order is MSB first; the packed layout fixes every bit offset.
    typedef struct packed {
        logic [CmdW-1:0]   command;
        logic [CoordW-1:0] x1, x2, x3;
        logic [CoordW-1:0] y1, y2, y3;
        logic [SlopeW-1:0] m1, m2, m3;
        logic [Z1W-1:0]    z1;
        logic [ZW-1:0]     mz, nz;
        logic [R1W-1:0]    r1;
        logic [RW-1:0]     mr, nr;
        logic [G1W-1:0]    g1;
        logic [GW-1:0]     mg, ng;
        logic [B1W-1:0]    b1;
        logic [BW-1:0]     mb, nb;
    } tri_rec_t;

    typedef struct packed {
        logic [CmdW-1:0]   command;
        logic [CoordW-1:0] y;
        logic [CoordW-1:0] xs;
        logic [CoordW-1:0] xe;
        logic              ldir;
        logic [ZW-1:0]     z;
        logic [RW-1:0]     r;
        logic [GW-1:0]     g;
        logic [BW-1:0]     b;
        logic [ZW-1:0]     nz;
        logic [RW-1:0]     nr;
        logic [GW-1:0]     ng;
        logic [BW-1:0]     nb;
    } span_rec_t;

    localparam int unsigned TriWidth  = $bits(tri_rec_t);
    localparam int unsigned SpanWidth = $bits(span_rec_t);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRow  = 1'b1;

    function automatic int sat_field(int v, int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Floor of an s7.6 edge position, clamped to the 0..63 screen range.
    function automatic logic [CoordW-1:0] x_sat(logic [XAccW-1:0] acc);
        if (acc[XAccW-1]) return '0;
        if (acc[XAccW-2]) return '1;
        return acc[XAccW-3:FracW];
    endfunction

endpackage

// File: rtl/span_walker_if.sv
// Setup-record FIFO read port and span FIFO write port of the span walker.
interface span_walker_if;
    import span_walker_pkg::*;

    logic [TriWidth-1:0]  triangle_data;
    logic                 triangle_empty;
    logic                 triangle_pull;
    logic [SpanWidth-1:0] span_data;
    logic                 span_full;
    logic                 span_push;

    modport master (
        input  triangle_data, triangle_empty, span_full,
        output triangle_pull, span_data, span_push
    );

    modport slave (
        output triangle_data, triangle_empty, span_full,
        input  triangle_pull, span_data, span_push
    );
endinterface

// File: rtl/edge_acc.sv
// Fixed-point DDA accumulator: load a start value, then per advance either add
// the step or jump to a reload value.
module edge_acc #(
    parameter int unsigned Width = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             advance_i,
    input  logic [Width-1:0] step_i,
    input  logic             reload_i,
    input  logic [Width-1:0] reload_val_i,
    output logic [Width-1:0] acc_o
);
    logic [Width-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= load_val_i;
        end else if (advance_i) begin
            acc_q <= reload_i ? reload_val_i : acc_q + step_i;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/span_walker.sv
// Walks a set-up triangle row by row from y1 to y3, emitting one span record
// per row with edge extents and long-edge attribute values.
module span_walker
    import span_walker_pkg::*;
(
    input logic          clk,
    input logic          rst,
    span_walker_if.master bus
);
    tri_rec_t          tri_in, rec_q;
    span_rec_t         span;
    logic [0:0]        state_q;
    logic [CoordW-1:0] y_q, y_next;
    logic              use_m3_q;
    logic              pull, push, last_row, reload_short;

    logic [XAccW-1:0]  long_x, short_x, short_step, short_load;
    logic [ZAccW-1:0]  z_acc;
    logic [RAccW-1:0]  r_acc;
    logic [GAccW-1:0]  g_acc;
    logic [BAccW-1:0]  b_acc;
    logic [CoordW-1:0] long_i, short_i;
    logic              unused_fields;

    assign tri_in = tri_rec_t'(bus.triangle_data);

    // Reset gates both strobes so a pending record is not consumed mid-reset.
    assign pull = (state_q == StIdle) && !bus.triangle_empty && !rst;
    assign push = (state_q == StRow) && !bus.span_full && !rst;
    assign bus.triangle_pull = pull;
    assign bus.span_push     = push;

    assign y_next       = y_q + 1'b1;
    assign last_row     = (y_q == rec_q.y3);
    assign reload_short = (y_next == rec_q.y2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            y_q      <= '0;
            use_m3_q <= 1'b0;
            rec_q    <= '0;
        end else if (pull) begin
            rec_q    <= tri_in;
            y_q      <= tri_in.y1;
            use_m3_q <= (tri_in.y1 == tri_in.y2);
            state_q  <= (tri_in.y1 == tri_in.y3) ? StIdle : StRow;
        end else if (push) begin
            if (last_row) begin
                state_q <= StIdle;
            end else begin
                y_q <= y_next;
                if (reload_short) use_m3_q <= 1'b1;
            end
        end
    end

    // A flat-top triangle starts the short edge at x2 already on its m3 slope.
    assign short_load = XAccW'({(tri_in.y1 == tri_in.y2) ? tri_in.x2 : tri_in.x1,
                                {FracW{1'b0}}});
    assign short_step = use_m3_q ? {rec_q.m3[SlopeW-1], rec_q.m3}
                                 : {rec_q.m2[SlopeW-1], rec_q.m2};

    edge_acc #(.Width(XAccW)) u_long_x (
        .clk(clk), .rst(rst), .load_i(pull),
        .load_val_i(XAccW'({tri_in.x1, {FracW{1'b0}}})),
        .advance_i(push), .step_i({rec_q.m1[SlopeW-1], rec_q.m1}),
        .reload_i(1'b0), .reload_val_i('0), .acc_o(long_x)
    );

    edge_acc #(.Width(XAccW)) u_short_x (
        .clk(clk), .rst(rst), .load_i(pull), .load_val_i(short_load),
        .advance_i(push), .step_i(short_step),
        .reload_i(reload_short), .reload_val_i(XAccW'({rec_q.x2, {FracW{1'b0}}})),
        .acc_o(short_x)
    );

    edge_acc #(.Width(ZAccW)) u_z (
        .clk(clk), .rst(rst), .load_i(pull),
        .load_val_i(ZAccW'({tri_in.z1, {FracW{1'b0}}})),
        .advance_i(push), .step_i({rec_q.mz[ZW-1], rec_q.mz}),
        .reload_i(1'b0), .reload_val_i('0), .acc_o(z_acc)
    );

    edge_acc #(.Width(RAccW)) u_r (
        .clk(clk), .rst(rst), .load_i(pull),
        .load_val_i(RAccW'({tri_in.r1, {FracW{1'b0}}})),
        .advance_i(push), .step_i({rec_q.mr[RW-1], rec_q.mr}),
        .reload_i(1'b0), .reload_val_i('0), .acc_o(r_acc)
    );

    edge_acc #(.Width(GAccW)) u_g (
        .clk(clk), .rst(rst), .load_i(pull),
        .load_val_i(GAccW'({tri_in.g1, {FracW{1'b0}}})),
        .advance_i(push), .step_i({rec_q.mg[GW-1], rec_q.mg}),
        .reload_i(1'b0), .reload_val_i('0), .acc_o(g_acc)
    );

    edge_acc #(.Width(BAccW)) u_b (
        .clk(clk), .rst(rst), .load_i(pull),
        .load_val_i(BAccW'({tri_in.b1, {FracW{1'b0}}})),
        .advance_i(push), .step_i({rec_q.mb[BW-1], rec_q.mb}),
        .reload_i(1'b0), .reload_val_i('0), .acc_o(b_acc)
    );

    assign long_i  = x_sat(long_x);
    assign short_i = x_sat(short_x);

    always_comb begin
        span = '0;
        if (state_q == StRow && !rst) begin
            span.command = rec_q.command;
            span.y       = y_q;
            span.xs      = (long_i <= short_i) ? long_i : short_i;
            span.xe      = (long_i <= short_i) ? short_i : long_i;
            span.ldir    = ($signed(long_x) <= $signed(short_x));
            span.z       = ZW'(sat_field(int'($signed(z_acc)), ZW));
            span.r       = RW'(sat_field(int'($signed(r_acc)), RW));
            span.g       = GW'(sat_field(int'($signed(g_acc)), GW));
            span.b       = BW'(sat_field(int'($signed(b_acc)), BW));
            span.nz      = rec_q.nz;
            span.nr      = rec_q.nr;
            span.ng      = rec_q.ng;
            span.nb      = rec_q.nb;
        end
    end

    assign bus.span_data = span;

    // Start values are taken straight from the input record; x3 is implied by slopes.
    assign unused_fields = ^{tri_in.x3, rec_q.x1, rec_q.x3, rec_q.y1, rec_q.z1,
                             rec_q.r1, rec_q.g1, rec_q.b1};
endmodule

// File: tb/tb_span_walker.sv
// Directed bench for span_walker: tabled triangles with hand-computed spans,
// then stall, back-to-back/degenerate and mid-triangle reset sequences.
module tb_span_walker;
    import span_walker_pkg::*;

    typedef struct packed {
        tri_rec_t rec;
        int       pushes;
    } vec_t;

    typedef struct packed {
        int v;
        int y;
        int xs;
        int xe;
        int ldir;
        int z;
    } chk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    span_walker_if sw_if ();
    span_walker dut (.clk(clk), .rst(rst), .bus(sw_if.master));

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;
    int bad_push  = 0;
    int bad_pull  = 0;
    span_rec_t cap[$];
    span_rec_t ref_q[$];
    int push_cyc[$];
    int pull_cyc[$];
    vec_t vecs[3];
    chk_t chks[10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sw_if.span_push) begin
            cap.push_back(span_rec_t'(sw_if.span_data));
            push_cyc.push_back(cyc);
            if (sw_if.span_full || rst) bad_push++;
        end
        if (sw_if.triangle_pull) begin
            pull_cyc.push_back(cyc);
            if (rst) bad_pull++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic tri_rec_t mk_tri(int cmd, int x1, int y1, int x2, int y2, int x3,
                                        int y3, int m1, int m2, int m3, int z1, int mz,
                                        int nz);
        tri_rec_t t;
        t         = '0;
        t.command = CmdW'(cmd);
        t.x1 = CoordW'(x1); t.y1 = CoordW'(y1);
        t.x2 = CoordW'(x2); t.y2 = CoordW'(y2);
        t.x3 = CoordW'(x3); t.y3 = CoordW'(y3);
        t.m1 = SlopeW'(m1); t.m2 = SlopeW'(m2); t.m3 = SlopeW'(m3);
        t.z1 = Z1W'(z1); t.mz = ZW'(mz); t.nz = ZW'(nz);
        t.r1 = 5'd3;  t.mr = 12'd5;  t.nr = 12'h5A5;
        t.g1 = 6'd9;  t.mg = 13'd7;  t.ng = 13'h1ABC;
        t.b1 = 5'd17; t.mb = 12'hFFE; t.nb = 12'h0F3;
        return t;
    endfunction

    function automatic int find_row(int y);
        foreach (cap[k]) if (int'(cap[k].y) == y) return k;
        return -1;
    endfunction

    // Call #1 after a rising edge; returns #1 after the edge that consumed the record.
    task automatic present_and_wait(output bit ok);
        sw_if.triangle_empty = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sw_if.triangle_pull) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_tri(input tri_rec_t rec, input int stall_after, input int stall_len,
                           input int budget);
        bit ok;
        int stalled;
        cap.delete(); push_cyc.delete(); pull_cyc.delete();
        bad_push = 0;
        stalled  = 0;
        sw_if.triangle_data = rec;
        present_and_wait(ok);
        check("pull_seen", ok, 1);
        sw_if.triangle_empty = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (stall_after >= 0 && cap.size() >= stall_after && stalled < stall_len) begin
                sw_if.span_full = 1'b1;
                stalled++;
            end else begin
                sw_if.span_full = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sw_if.span_full = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok1, ok2, ok3, seq_ok;
        int k, n, rst_bad;
        tri_rec_t deg;

        vecs[0] = '{rec: mk_tri(8'hA5, 10, 0, 20, 10, 0, 20, -32, 64, -128, 100, 128, 4660),
                    pushes: 21};
        vecs[1] = '{rec: mk_tri(8'h3C, 5, 3, 25, 3, 15, 13, 64, 448, -64, 0, -64, -5),
                    pushes: 11};
        vecs[2] = '{rec: mk_tri(8'h81, 60, 0, 2, 0, 63, 1, 512, 0, -256, 1023, 65535, 0),
                    pushes: 2};
        deg = mk_tri(8'h11, 5, 7, 9, 7, 30, 7, 64, 64, 64, 1, 1, 1);

        chks[0] = '{v: 0, y: 0,  xs: 10, xe: 10, ldir: 1, z: 6400};
        chks[1] = '{v: 0, y: 5,  xs: 7,  xe: 15, ldir: 1, z: 7040};
        chks[2] = '{v: 0, y: 10, xs: 5,  xe: 20, ldir: 1, z: 7680};
        chks[3] = '{v: 0, y: 15, xs: 2,  xe: 10, ldir: 1, z: 8320};
        chks[4] = '{v: 0, y: 20, xs: 0,  xe: 0,  ldir: 1, z: 8960};
        chks[5] = '{v: 1, y: 3,  xs: 5,  xe: 25, ldir: 1, z: 0};
        chks[6] = '{v: 1, y: 8,  xs: 10, xe: 20, ldir: 1, z: -320};
        chks[7] = '{v: 1, y: 13, xs: 15, xe: 15, ldir: 1, z: -640};
        chks[8] = '{v: 2, y: 0,  xs: 2,  xe: 60, ldir: 0, z: 65472};
        chks[9] = '{v: 2, y: 1,  xs: 0,  xe: 63, ldir: 0, z: 65535};

        // Reset state, with a record on offer that must not be pulled.
        rst = 1'b1;
        sw_if.span_full      = 1'b0;
        sw_if.triangle_empty = 1'b0;
        sw_if.triangle_data  = vecs[0].rec;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pull", sw_if.triangle_pull, 0);
        check("rst_push", sw_if.span_push, 0);
        check("rst_span_data_zero", (sw_if.span_data == '0), 1);
        @(posedge clk);
        #1;
        sw_if.triangle_empty = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_empty_no_pull", sw_if.triangle_pull, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            run_tri(vecs[i].rec, -1, 0, 40);
            check($sformatf("v%0d_pushes", i), cap.size(), vecs[i].pushes);
            check($sformatf("v%0d_pulls", i), pull_cyc.size(), 1);
            seq_ok = 1'b1;
            foreach (cap[j]) begin
                if (int'(cap[j].y) != int'(vecs[i].rec.y1) + j ||
                    cap[j].command != vecs[i].rec.command || cap[j].nz != vecs[i].rec.nz ||
                    cap[j].nr != vecs[i].rec.nr || cap[j].ng != vecs[i].rec.ng ||
                    cap[j].nb != vecs[i].rec.nb)
                    seq_ok = 1'b0;
            end
            check($sformatf("v%0d_order_passthru", i), seq_ok, 1);
            foreach (chks[c]) begin
                if (chks[c].v == i) begin
                    k = find_row(chks[c].y);
                    check($sformatf("v%0d_y%0d_present", i, chks[c].y), (k >= 0), 1);
                    if (k >= 0) begin
                        check($sformatf("v%0d_y%0d_xs", i, chks[c].y), cap[k].xs, chks[c].xs);
                        check($sformatf("v%0d_y%0d_xe", i, chks[c].y), cap[k].xe, chks[c].xe);
                        check($sformatf("v%0d_y%0d_ldir", i, chks[c].y), cap[k].ldir,
                              chks[c].ldir);
                        check($sformatf("v%0d_y%0d_z", i, chks[c].y),
                              int'($signed(cap[k].z)), chks[c].z);
                    end
                end
            end
            if (i == 0) ref_q = cap;
        end

        // Three-cycle stall after four rows.
        run_tri(vecs[0].rec, 4, 3, 50);
        check("stall_pushes", cap.size(), 21);
        check("stall_push_while_full", bad_push, 0);
        seq_ok = (cap.size() == ref_q.size());
        foreach (cap[j]) if (j < ref_q.size() && cap[j] != ref_q[j]) seq_ok = 1'b0;
        check("stall_sequence_same", seq_ok, 1);
        if (push_cyc.size() == 21)
            check("stall_span_cycles", push_cyc[20] - push_cyc[0], 23);

        // Degenerate, flat-top and saturating records offered back to back.
        cap.delete(); push_cyc.delete(); pull_cyc.delete();
        sw_if.triangle_data = deg;
        present_and_wait(ok1);
        sw_if.triangle_data = vecs[1].rec;
        present_and_wait(ok2);
        sw_if.triangle_data = vecs[2].rec;
        present_and_wait(ok3);
        sw_if.triangle_empty = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("b2b_all_pulled", ok1 & ok2 & ok3, 1);
        check("b2b_pull_count", pull_cyc.size(), 3);
        check("b2b_push_count", cap.size(), 13);
        if (pull_cyc.size() == 3 && push_cyc.size() >= 11) begin
            check("deg_next_pull_gap", pull_cyc[1] - pull_cyc[0], 1);
            check("first_push_latency", push_cyc[0] - pull_cyc[1], 1);
            check("pull_after_last_push", pull_cyc[2] - push_cyc[10], 1);
            n = 0;
            foreach (push_cyc[j]) if (push_cyc[j] < pull_cyc[2]) n++;
            check("flat_pushes_before_next", n, 11);
            check("deg_no_span_first_y", cap[0].y, 3);
        end

        // Reset at row 4 with the next record already waiting.
        cap.delete(); push_cyc.delete(); pull_cyc.delete();
        bad_push = 0; bad_pull = 0; rst_bad = 0;
        sw_if.triangle_data = vecs[0].rec;
        present_and_wait(ok1);
        sw_if.triangle_data = vecs[1].rec;
        for (int c = 0; c < 40; c++) begin
            if (cap.size() >= 4) break;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (sw_if.span_push || sw_if.triangle_pull || sw_if.span_data != '0) rst_bad++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        present_and_wait(ok2);
        sw_if.triangle_empty = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_pulls_ok", ok1 & ok2, 1);
        check("rst_outputs_quiet", rst_bad, 0);
        check("rst_no_pull_during_rst", bad_pull, 0);
        check("rst_total_pushes", cap.size(), 15);
        check("rst_pull_count", pull_cyc.size(), 2);
        if (cap.size() == 15) begin
            check("rst_next_first_y", cap[4].y, 3);
            check("rst_next_first_xs", cap[4].xs, 5);
            check("rst_next_first_xe", cap[4].xe, 25);
            check("rst_next_last_xs", cap[14].xs, 15);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
